// File: rtl/fifo_axis_rd_adapter_if.sv
// Bundle of the FIFO read-side handshake and the AXI-Stream master signals
// used by fifo_axis_rd_adapter; master = adapter side, slave = environment.
interface fifo_axis_rd_adapter_if #(
  parameter int unsigned DATA_W = 16
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [15:0]       beat_count;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  m_axis_tready,
    output fifo_rd_en,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    output beat_count
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output m_axis_tready,
    input  fifo_rd_en,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    input  beat_count
  );
endinterface

// File: rtl/fifo_axis_rd_adapter.sv
// Async-FIFO read side to AXI-Stream adapter with a 2-entry registered skid buffer.
// Optional packet framing (tlast every PKT_LEN beats) enabled by FIFO_AXIS_TLAST_EN.
module fifo_axis_rd_adapter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PKT_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  fifo_axis_rd_adapter_if.master bus
);

  if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_pkt_len_check
    $error("fifo_axis_rd_adapter: PKT_LEN must be within 1..65535");
  end

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic [15:0]       beat_count_q, beat_count_d;
  logic              push;
  logic              pop;

  // Pop request never looks at tready, so the FIFO path stays short.
  assign push = !reset && !bus.fifo_empty && (occ_q != OCC_TWO);
  assign pop  = (occ_q != OCC_EMPTY) && bus.m_axis_tready;

`ifdef FIFO_AXIS_TLAST_EN
  localparam logic [15:0] PKT_LAST = 16'(PKT_LEN - 1);

  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        head_last_q, head_last_d;
  logic        tail_last_q, tail_last_d;
  logic        push_last;

  assign push_last = (pkt_cnt_q == PKT_LAST);

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (push) begin
      pkt_cnt_d = push_last ? '0 : pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
`endif

  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    tail_data_d = tail_data_q;
`ifdef FIFO_AXIS_TLAST_EN
    head_last_d = head_last_q;
    tail_last_d = tail_last_q;
`endif
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_data_d = bus.fifo_rd_data;
`ifdef FIFO_AXIS_TLAST_EN
          head_last_d = push_last;
`endif
          occ_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          // Head leaves and the incoming word takes its place directly.
          head_data_d = bus.fifo_rd_data;
`ifdef FIFO_AXIS_TLAST_EN
          head_last_d = push_last;
`endif
        end else if (push) begin
          tail_data_d = bus.fifo_rd_data;
`ifdef FIFO_AXIS_TLAST_EN
          tail_last_d = push_last;
`endif
          occ_d = OCC_TWO;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          head_data_d = tail_data_q;
`ifdef FIFO_AXIS_TLAST_EN
          head_last_d = tail_last_q;
`endif
          occ_d = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_comb begin
    beat_count_d = beat_count_q;
    if (pop) begin
      beat_count_d = beat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q        <= OCC_EMPTY;
      head_data_q  <= '0;
      tail_data_q  <= '0;
      beat_count_q <= '0;
`ifdef FIFO_AXIS_TLAST_EN
      head_last_q  <= 1'b0;
      tail_last_q  <= 1'b0;
`endif
    end else begin
      occ_q        <= occ_d;
      head_data_q  <= head_data_d;
      tail_data_q  <= tail_data_d;
      beat_count_q <= beat_count_d;
`ifdef FIFO_AXIS_TLAST_EN
      head_last_q  <= head_last_d;
      tail_last_q  <= tail_last_d;
`endif
    end
  end

  assign bus.fifo_rd_en    = push;
  assign bus.m_axis_tvalid = (occ_q != OCC_EMPTY);
  assign bus.m_axis_tdata  = head_data_q;
  assign bus.beat_count    = beat_count_q;
`ifdef FIFO_AXIS_TLAST_EN
  assign bus.m_axis_tlast  = head_last_q;
`else
  assign bus.m_axis_tlast  = 1'b0;
`endif

endmodule

// File: doc/fifo_axis_rd_adapter.md
FIFO_AXIS_RD_ADAPTER -- requirements
Module: fifo_axis_rd_adapter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data width; it matches the async FIFO read-data width.
REQ-002 Parameter PKT_LEN, default 16, SHALL set the beats per packet; legal range 1..65535.
REQ-003 clk  input  1: single clock, the FIFO read-side clock; all logic SHALL be rising-edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 fifo_empty  input  1: FIFO empty flag, synchronous to clk.
REQ-006 fifo_rd_data  input  DATA_W: FIFO read word, valid only in the same cycle that fifo_rd_en=1 and fifo_empty=0.
REQ-007 fifo_rd_en  output  1: FIFO pop request.
REQ-008 m_axis_tdata  output  DATA_W: stream data.
REQ-009 m_axis_tvalid  output  1: stream valid.
REQ-010 m_axis_tready  input  1: downstream ready.
REQ-011 m_axis_tlast  output  1: last beat of a packet.
REQ-012 beat_count  output  16: total beats accepted downstream, wraps 0xFFFF->0x0000.

Function
REQ-013 The block SHALL contain a 2-entry skid buffer with occupancy states EMPTY (0), ONE (1) and TWO (2).
REQ-014 fifo_rd_en SHALL be driven combinationally as (!fifo_empty && occupancy!=TWO); it SHALL NOT depend on m_axis_tready.
REQ-015 Push: when fifo_rd_en=1, fifo_rd_data SHALL be written into the buffer at that rising edge.
REQ-016 Pop: a beat transfers when m_axis_tvalid && m_axis_tready at a rising edge; the head entry is then removed.
REQ-017 Transitions: EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; ONE stays ONE on push+pop; TWO->ONE on pop (no push is possible in TWO).
REQ-018 m_axis_tvalid SHALL be 1 exactly when occupancy!=EMPTY; m_axis_tdata SHALL be the oldest entry and SHALL be driven from registers.
REQ-019 Latency: a word popped from the FIFO at edge N SHALL appear on m_axis_tdata with tvalid=1 after edge N.
REQ-020 Throughput: with fifo_empty=0 and tready=1 held, the block SHALL transfer one beat per cycle.
REQ-021 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable.
REQ-022 Ordering SHALL be strict FIFO order; no word SHALL be dropped or duplicated.
REQ-023 beat_count SHALL increment by 1 on every transfer.
REQ-024 The buffer SHALL store a tlast bit alongside each data entry; the tlast value is computed at push time.

Reset
REQ-025 While reset=1: occupancy=EMPTY, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, beat_count=0, packet counter=0, fifo_rd_en=0.
REQ-026 Assertion of reset mid-packet SHALL discard buffered words immediately and asynchronously; after release the next pushed word SHALL be packet beat 0.
REQ-027 No push or pop SHALL occur on the first rising edge at which reset is sampled high.

Configuration
REQ-028 Macro FIFO_AXIS_TLAST_EN: when defined, a push-side counter SHALL run 0..PKT_LEN-1, increment on each push, and wrap to 0; the pushed entry's tlast SHALL be 1 when the counter equals PKT_LEN-1.
REQ-029 When FIFO_AXIS_TLAST_EN is not defined, m_axis_tlast SHALL be constant 0 and the packet counter SHALL not exist.

Verification
REQ-030 FIFO supplies 0x0001..0x0008 back-to-back with tready=1: fifo_rd_en high 8 cycles; 8 transfers on consecutive cycles in order; beat_count=8.
REQ-031 tready=0 with words available: occupancy reaches TWO; fifo_rd_en drops; tdata holds the first word. tready=1: drain without loss; fifo_rd_en reasserts the cycle after TWO->ONE.
REQ-032 fifo_empty toggles every cycle with tready=1: tvalid gaps follow the empty gaps; no duplicate data.
REQ-033 FIFO_AXIS_TLAST_EN defined, PKT_LEN=4, 12 words: tlast=1 on beats 4, 8 and 12 only, including under random tready backpressure.
REQ-034 reset pulsed while occupancy=TWO and mid-packet: tvalid=0 asynchronously; after release, beat_count=0 and the next 4 beats end with tlast on beat 4 (PKT_LEN=4).
REQ-035 Force beat_count to 0xFFFE, then transfer 3 beats: beat_count reads 0x0001.
